// File: rtl/gt_reset_pkg.sv
// Shared constants for the GT transceiver TX/RX reset sequencers.
package gt_reset_pkg;

   localparam int ST_W    = 6;
   localparam int RETRY_W = 3;

   // One-hot state encodings, common to both sequencer directions
   localparam logic [ST_W-1:0] ST_PWR_WAIT  = 6'b000001;
   localparam logic [ST_W-1:0] ST_RESET     = 6'b000010;
   localparam logic [ST_W-1:0] ST_WAIT_DONE = 6'b000100;
   localparam logic [ST_W-1:0] ST_STABLE    = 6'b001000;
   localparam logic [ST_W-1:0] ST_UP        = 6'b010000;
   localparam logic [ST_W-1:0] ST_FAULT     = 6'b100000;

   localparam logic [RETRY_W-1:0] RETRY_SAT = 3'd7;

   // Retry count increment that sticks at the saturation limit
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] r);
      return (r == RETRY_SAT) ? RETRY_SAT : r + 3'd1;
   endfunction

endpackage

// File: rtl/reset_timer.sv
// Cycle counter with synchronous clear, enable and a terminal-count compare.
module reset_timer #(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_cmp,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   // Count up while enabled; clear has priority
   always_ff @(posedge clk) begin
      if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_tc = (r_cnt == i_cmp);

endmodule

// File: rtl/tx_reset_seq.sv
// TX reset sequencer for a GT transceiver channel.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PWR_WAIT   | waiting for PWR_WAIT_CYC cycles of continuous pll_lock
// RESET      | driving the gtwiz_tx_reset pulse for RST_PULSE_CYC cycles
// WAIT_DONE  | waiting for tx_reset_done, bounded by DONE_TIMEOUT
// STABLE     | qualifying tx_reset_done high for STABLE_CYC cycles
// UP         | TX side ready
// FAULT      | retry budget exhausted; left only by reset or force_reset
module tx_reset_seq
   import gt_reset_pkg::*;
#(
   parameter int PWR_WAIT_CYC  = 64,
   parameter int RST_PULSE_CYC = 32,
   parameter int DONE_TIMEOUT  = 2**26,
   parameter int STABLE_CYC    = 1024,
   parameter int MAX_RETRY     = 4,
   parameter int CNT_W         = 27
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               tx_reset_done,
   input  logic               force_reset,
   output logic               gtwiz_tx_reset,
   output logic               tx_ready,
   output logic               tx_fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [ST_W-1:0]    state_dbg
);

   logic [ST_W-1:0]    r_state;
   logic [RETRY_W-1:0] r_retry;
   logic               r_gtwiz;
   logic               r_ready;
   logic               r_fault;

   logic [ST_W-1:0]    w_state_nxt;
   logic [RETRY_W-1:0] w_retry_nxt;
   logic [RETRY_W-1:0] w_retry_inc;
   logic [CNT_W-1:0]   w_cmp;
   logic               w_tc;
   logic               w_tmr_clr;
   logic               w_tmr_en;

   assign w_retry_inc = retry_inc(r_retry);

   // Terminal-count value for the state currently being timed
   always_comb begin
      w_cmp = '0;
      case (r_state)
         ST_PWR_WAIT:  w_cmp = CNT_W'(PWR_WAIT_CYC - 1);
         ST_RESET:     w_cmp = CNT_W'(RST_PULSE_CYC - 1);
         ST_WAIT_DONE: w_cmp = CNT_W'(DONE_TIMEOUT - 1);
         ST_STABLE:    w_cmp = CNT_W'(STABLE_CYC - 1);
         default:      w_cmp = '0;
      endcase
   end

   // Next state and retry count; force_reset and lock loss override the normal flow
   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      if (force_reset) begin
         w_state_nxt = ST_RESET;
         w_retry_nxt = '0;
      end else if (!pll_lock && (r_state != ST_PWR_WAIT) && (r_state != ST_FAULT)) begin
         w_state_nxt = ST_PWR_WAIT;
      end else begin
         case (r_state)
            ST_PWR_WAIT: begin
               if (pll_lock && w_tc)
                  w_state_nxt = ST_RESET;
            end
            ST_RESET: begin
               if (w_tc)
                  w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (tx_reset_done) begin
                  w_state_nxt = ST_STABLE;
               end else if (w_tc) begin
                  w_retry_nxt = w_retry_inc;
                  if (32'(w_retry_inc) >= MAX_RETRY)
                     w_state_nxt = ST_FAULT;
                  else
                     w_state_nxt = ST_RESET;
               end
            end
            ST_STABLE: begin
               if (!tx_reset_done) begin
                  w_state_nxt = ST_WAIT_DONE;
               end else if (w_tc) begin
                  w_state_nxt = ST_UP;
                  w_retry_nxt = '0;
               end
            end
            ST_UP: begin
               if (!tx_reset_done)
                  w_state_nxt = ST_RESET;
            end
            ST_FAULT: begin
               w_state_nxt = ST_FAULT;
            end
            default: begin
               w_state_nxt = ST_PWR_WAIT;
            end
         endcase
      end
   end

   // Counter restarts on every state entry, on a forced restart, and while lock is low in PWR_WAIT
   assign w_tmr_clr = !reset || force_reset || (w_state_nxt != r_state) ||
                      ((r_state == ST_PWR_WAIT) && !pll_lock);
   assign w_tmr_en  = (r_state == ST_PWR_WAIT) || (r_state == ST_RESET) ||
                      (r_state == ST_WAIT_DONE) || (r_state == ST_STABLE);

   reset_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .i_clr (w_tmr_clr),
      .i_en  (w_tmr_en),
      .i_cmp (w_cmp),
      .o_tc  (w_tc)
   );

   // State, retry count and outputs all register from the next-state value
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_PWR_WAIT;
         r_retry <= '0;
         r_gtwiz <= 1'b1;
         r_ready <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_retry <= w_retry_nxt;
         r_gtwiz <= (w_state_nxt == ST_PWR_WAIT) || (w_state_nxt == ST_RESET) ||
                    (w_state_nxt == ST_FAULT);
         r_ready <= (w_state_nxt == ST_UP);
         r_fault <= (w_state_nxt == ST_FAULT);
      end
   end

   assign gtwiz_tx_reset = r_gtwiz;
   assign tx_ready       = r_ready;
   assign tx_fault       = r_fault;
   assign retry_cnt      = r_retry;
   assign state_dbg      = r_state;

endmodule
